fft_frame_sequencer: RTL and testbench

Controller that sequences the 8-point FFT datapath for one frame at a time. It collects eight real input samples from a streaming source, presents them to the FFT core, and pulses the core's start. It waits for the core's done, captures the eight complex bins, and emits them in bin order (0..7) on a valid/ready output port. The output port feeds the bin serializer/display path; this block replaces free-running output cycling with explicit frame control.

---
 rtl/fft_seq_pkg.sv | 19 +
 rtl/fft_frame_sequencer_if.sv | 32 +++
 rtl/fft_seq_tick_gen.sv | 25 ++
 rtl/fft_frame_sequencer.sv | 100 ++++++++++
 tb/tb_fft_frame_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fft_seq_pkg.sv
// Shared state type and index constants for the 8-point FFT frame sequencer.
package fft_seq_pkg;

    localparam int N_POINTS = 8;
    localparam int INDEX_W  = 3;

    typedef enum logic [1:0] {LOAD, START, WAIT, EMIT} state_t;

    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(N_POINTS - 1);

    // DC and Nyquist bins of a real-input FFT have no imaginary part.
    localparam logic [INDEX_W-1:0] BIN_DC  = 3'd0;
    localparam logic [INDEX_W-1:0] BIN_NYQ = 3'd4;

    function automatic logic is_real_bin(input logic [INDEX_W-1:0] idx);
        return (idx == BIN_DC) || (idx == BIN_NYQ);
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Sample stream, FFT core and bin output signals of the frame sequencer.
interface fft_frame_sequencer_if #(
    parameter int DATA_W = 16
);
    logic signed [DATA_W-1:0]   samp_in;
    logic                       samp_valid;
    logic                       samp_ready;
    logic        [8*DATA_W-1:0] fft_x;
    logic                       fft_start;
    logic                       fft_done;
    logic        [8*DATA_W-1:0] fft_re;
    logic        [8*DATA_W-1:0] fft_im;
    logic signed [DATA_W-1:0]   out_re;
    logic signed [DATA_W-1:0]   out_im;
    logic        [2:0]          out_index;
    logic                       out_valid;
    logic                       out_ready;
    logic                       busy;
    logic        [7:0]          frame_count;

    modport master (
        input  samp_in, samp_valid, fft_done, fft_re, fft_im, out_ready,
        output samp_ready, fft_x, fft_start, out_re, out_im, out_index,
               out_valid, busy, frame_count
    );

    modport slave (
        output samp_in, samp_valid, fft_done, fft_re, fft_im, out_ready,
        input  samp_ready, fft_x, fft_start, out_re, out_im, out_index,
               out_valid, busy, frame_count
    );
endinterface

// File: rtl/fft_seq_tick_gen.sv
// Free-running pacing tick: one-cycle pulse every TICK_DIV fastclk cycles.
module fft_seq_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic fastclk,
    input  logic rst_n,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge fastclk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);
endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the 8-point FFT: load 8 samples, start core, await done, emit bins 0..7.
// Define FFT_SEQ_PACE_EN to throttle emission to at most one bin per TICK_DIV cycles.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 50000000
) (
    input logic fastclk,
    input logic rst_n,
    fft_frame_sequencer_if.master bus
);
    state_t                     state;
    logic [INDEX_W-1:0]         load_cnt;
    logic [INDEX_W-1:0]         emit_idx;
    logic [7:0]                 frame_count;
    logic                       vld_p1;
    logic [N_POINTS*DATA_W-1:0] x_p0;
    logic [N_POINTS*DATA_W-1:0] res_re_p1;
    logic [N_POINTS*DATA_W-1:0] res_im_p1;
    logic                       xfer;

    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("TICK_DIV must be at least 2");
    end

`ifdef FFT_SEQ_PACE_EN
    logic tick;

    fft_seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .fastclk (fastclk),
        .rst_n   (rst_n),
        .tick    (tick)
    );
`endif

    assign xfer = (state == EMIT) && vld_p1 && bus.out_ready;

    always_ff @(posedge fastclk) begin
        if (!rst_n) begin
            state       <= LOAD;
            load_cnt    <= '0;
            emit_idx    <= '0;
            frame_count <= '0;
            vld_p1      <= 1'b0;
            x_p0        <= '0;
            res_re_p1   <= '0;
            res_im_p1   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.samp_valid) begin
                        x_p0[load_cnt*DATA_W +: DATA_W] <= bus.samp_in;
                        load_cnt <= load_cnt + 1'b1;
                        if (load_cnt == LAST_IDX) state <= START;
                    end
                end
                START: state <= WAIT;
                // p0 -> p1: capture all bins at once so emission is decoupled from the core
                WAIT: begin
                    if (bus.fft_done) begin
                        res_re_p1 <= bus.fft_re;
                        res_im_p1 <= bus.fft_im;
                        emit_idx  <= '0;
                        state     <= EMIT;
`ifndef FFT_SEQ_PACE_EN
                        vld_p1    <= 1'b1;
`endif
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        emit_idx <= emit_idx + 1'b1;
                        if (emit_idx == LAST_IDX) begin
                            frame_count <= frame_count + 1'b1;
                            vld_p1      <= 1'b0;
                            state       <= LOAD;
                        end
`ifdef FFT_SEQ_PACE_EN
                        vld_p1 <= 1'b0;
                    end else if (!vld_p1 && tick) begin
                        vld_p1 <= 1'b1;
`endif
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.samp_ready  = (state == LOAD);
    assign bus.busy        = (state != LOAD);
    assign bus.fft_start   = (state == START);
    assign bus.fft_x       = x_p0;
    assign bus.frame_count = frame_count;
    assign bus.out_valid   = vld_p1;
    assign bus.out_index   = emit_idx;
    assign bus.out_re      = res_re_p1[emit_idx*DATA_W +: DATA_W];
    assign bus.out_im      = is_real_bin(emit_idx) ? '0 : res_im_p1[emit_idx*DATA_W +: DATA_W];
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer: directed frames, stalls, ignored dones and mid-frame reset.
module tb_fft_frame_sequencer;
    localparam int DW = 16;

    typedef struct {
        logic [2:0]    idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } bin_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_xfer   = 0;
    bin_t exp_q[$];

    always #5 clk = ~clk;

    fft_frame_sequencer_if #(.DATA_W(DW)) bus();

    fft_frame_sequencer #(.DATA_W(DW), .TICK_DIV(4)) dut (
        .fastclk (clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Monitor: every accepted bin must match the head of the expected queue
    always @(negedge clk) begin : mon
        bin_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
                check("unexpected_bin", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("bin_index", {125'b0, bus.out_index}, {125'b0, e.idx});
                check("bin_re", {112'b0, bus.out_re}, {112'b0, e.re});
                check("bin_im", {112'b0, bus.out_im}, {112'b0, e.im});
            end
        end
    end

    task automatic load_frame(input int base, input bit done_mid, input bit done_start);
        logic [8*DW-1:0] ex;
        ex = '0;
        for (int i = 0; i < 8; i++) begin
            bus.samp_in    = DW'(base + i);
            bus.samp_valid = 1'b1;
            bus.fft_done   = done_mid && (i == 3);
            ex[i*DW +: DW] = DW'(base + i);
            if (i == 7) check("samp_ready_load", bus.samp_ready, 1);
            @(posedge clk); #1;
        end
        bus.samp_valid = 1'b0;
        bus.fft_done   = done_start;
        check("samp_ready_start", bus.samp_ready, 0);
        check("fft_start_hi", bus.fft_start, 1);
        check("busy_start", bus.busy, 1);
        check("fft_x", bus.fft_x, ex);
        @(posedge clk); #1;
        bus.fft_done = 1'b0;
        check("fft_start_lo", bus.fft_start, 0);
        check("wait_no_valid", bus.out_valid, 0);
    endtask

    task automatic core_frame(input int re_base, input int im_base, input int delay, input bit unpaced);
        logic [DW-1:0] r;
        logic [DW-1:0] m;
        bin_t b;
        for (int k = 0; k < 8; k++) begin
            r = DW'(re_base + k);
            m = DW'(im_base + k);
            bus.fft_re[k*DW +: DW] = r;
            bus.fft_im[k*DW +: DW] = m;
            b.idx = 3'(k);
            b.re  = r;
            b.im  = (k == 0 || k == 4) ? '0 : m;
            exp_q.push_back(b);
        end
        repeat (delay) begin
            @(posedge clk); #1;
        end
        check("wait_hold", bus.out_valid, 0);
        bus.fft_done = 1'b1;
        @(posedge clk); #1;
        bus.fft_done = 1'b0;
        if (unpaced) begin
            check("valid_after_done", bus.out_valid, 1);
            check("first_index", bus.out_index, 0);
        end
    endtask

    initial begin
        bus.samp_in    = '0;
        bus.samp_valid = 1'b0;
        bus.fft_done   = 1'b0;
        bus.fft_re     = '0;
        bus.fft_im     = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_samp_ready", bus.samp_ready, 1);
        check("rst_fft_start", bus.fft_start, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_re", {112'b0, bus.out_re}, 0);
        check("rst_out_im", {112'b0, bus.out_im}, 0);
        check("rst_out_index", bus.out_index, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_count", bus.frame_count, 0);
        check("rst_fft_x", bus.fft_x, 0);
        rst_n = 1'b1;

`ifdef FFT_SEQ_PACE_EN
        begin
            int  nr;
            int  first;
            int  last;
            logic prev;
            nr = 0; first = 0; last = 0; prev = 1'b0;
            bus.out_ready = 1'b1;
            load_frame(1, 1'b0, 1'b0);
            core_frame(100, 200, 0, 1'b0);
            for (int c = 0; c < 200 && bus.frame_count == 0; c++) begin
                if (bus.out_valid && !prev) begin
                    if (nr > 0) check("pace_gap", c - last, 4);
                    else first = c;
                    last = c;
                    nr++;
                end
                prev = bus.out_valid;
                @(posedge clk); #1;
            end
            check("pace_rises", nr, 8);
            check("pace_span", last - first, 28);
            check("pace_frame_count", bus.frame_count, 1);
        end
`else
        // Frame 1: ready held high, bins stream in 8 consecutive cycles
        bus.out_ready = 1'b1;
        load_frame(1, 1'b0, 1'b0);
        core_frame(100, 200, 2, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("f1_samp_ready", bus.samp_ready, 1);
        check("f1_out_valid", bus.out_valid, 0);
        check("f1_frame_count", bus.frame_count, 1);
        check("f1_xfers", n_xfer, 8);

        // Frame 2: stray dones in LOAD and START, then a 5-cycle stall at bin 3
        load_frame(1, 1'b1, 1'b1);
        core_frame(100, 200, 3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_index", bus.out_index, 3);
            check("stall_re", {112'b0, bus.out_re}, 103);
            check("stall_im", {112'b0, bus.out_im}, 203);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("f2_frame_count", bus.frame_count, 2);
        check("f2_xfers", n_xfer, 16);
        check("f2_samp_ready", bus.samp_ready, 1);

        // Frame 3: reset while bin 5 is presented
        load_frame(11, 1'b0, 1'b0);
        core_frame(100, 200, 1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_index", bus.out_index, 5);
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_samp_ready", bus.samp_ready, 1);
        check("mid_rst_frame_count", bus.frame_count, 0);
        check("mid_rst_index", bus.out_index, 0);
        check("mid_rst_busy", bus.busy, 0);
        exp_q.delete();

        // Frame 4: fresh frame after reset, negative values, nonzero im on real-only bins
        bus.out_ready = 1'b1;
        load_frame(21, 1'b0, 1'b0);
        core_frame(-50, -3, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("f4_frame_count", bus.frame_count, 1);
        check("f4_xfers", n_xfer, 29);
        check("f4_samp_ready", bus.samp_ready, 1);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
